// File: rtl/lcd_spi_tx_if.sv
// Operation handshake between a panel-sequencing producer and the LCD SPI transmitter.
// The producer holds spi_start and the operands; the transmitter answers with spi_ready/busy.
interface lcd_spi_tx_if;
    logic       spi_start;
    logic [7:0] spi_data;
    logic [1:0] spi_cmd;
    logic       spi_ready;
    logic       busy;

    modport master (output spi_start, spi_data, spi_cmd, input spi_ready, busy);
    modport slave  (input spi_start, spi_data, spi_cmd, output spi_ready, busy);
endinterface

// File: rtl/lcd_spi_tx.sv
// Byte-level SPI mode-0 transmitter for the LCD panel, with panel reset pulse and timed delay
// operations sequenced through the same four-phase start/ready handshake.
module lcd_spi_tx #(
    parameter int CLK_DIV      = 2,
    parameter int RST_CYCLES   = 20,
    parameter int DELAY_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         reset,
    lcd_spi_tx_if.slave  bus,
    output logic         lcd_sclk,
    output logic         lcd_mosi,
    output logic         lcd_cs_n,
    output logic         lcd_dc,
    output logic         lcd_rst_n
);
    // HOLD keeps CS low for one phase, then spends one more phase deselected before acking.
    localparam int HOLD_CYCLES = 2 * CLK_DIV;
    localparam int MAX_A       = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
    localparam int MAX_C       = (MAX_A > DELAY_CYCLES) ? MAX_A : DELAY_CYCLES;
    localparam int CW          = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] LD_PHASE = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LD_RST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LD_DELAY = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0] CS_REL   = CW'(CLK_DIV);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, RSTPULSE, WAIT, ACK
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic            sclk_nxt, mosi_nxt, cs_n_nxt, dc_nxt, rst_n_nxt, ready_nxt, busy_nxt;
    logic            phase_done;

    assign phase_done = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            lcd_sclk      <= 1'b0;
            lcd_mosi      <= 1'b0;
            lcd_cs_n      <= 1'b1;
            lcd_dc        <= 1'b0;
            lcd_rst_n     <= 1'b1;
            bus.spi_ready <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            bit_cnt       <= bit_cnt_nxt;
            shreg         <= shreg_nxt;
            lcd_sclk      <= sclk_nxt;
            lcd_mosi      <= mosi_nxt;
            lcd_cs_n      <= cs_n_nxt;
            lcd_dc        <= dc_nxt;
            lcd_rst_n     <= rst_n_nxt;
            bus.spi_ready <= ready_nxt;
            bus.busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.spi_start) begin
                    case (bus.spi_cmd)
                        2'b01:   state_nxt = RSTPULSE;
                        2'b11:   state_nxt = WAIT;
                        default: state_nxt = SETUP;
                    endcase
                end
            end
            SETUP:    if (phase_done) state_nxt = SHIFT_HI;
            SHIFT_HI: if (phase_done) state_nxt = (bit_cnt == 3'd7) ? HOLD : SHIFT_LO;
            SHIFT_LO: if (phase_done) state_nxt = SHIFT_HI;
            HOLD:     if (phase_done) state_nxt = ACK;
            RSTPULSE: if (phase_done) state_nxt = ACK;
            WAIT:     if (phase_done) state_nxt = ACK;
            ACK:      if (!bus.spi_start) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt     = phase_done ? cnt : cnt - 1'b1;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        sclk_nxt    = lcd_sclk;
        mosi_nxt    = lcd_mosi;
        cs_n_nxt    = lcd_cs_n;
        dc_nxt      = lcd_dc;
        rst_n_nxt   = lcd_rst_n;
        ready_nxt   = bus.spi_ready;
        busy_nxt    = bus.busy;

        // Every phase change reloads the shared cycle counter for the phase being entered.
        if (state_nxt != state) begin
            case (state_nxt)
                SETUP, SHIFT_HI, SHIFT_LO: cnt_nxt = LD_PHASE;
                HOLD:                      cnt_nxt = LD_HOLD;
                RSTPULSE:                  cnt_nxt = LD_RST;
                WAIT:                      cnt_nxt = LD_DELAY;
                default:                   cnt_nxt = '0;
            endcase
        end

        case (state)
            IDLE: begin
                if (bus.spi_start) begin
                    busy_nxt    = 1'b1;
                    shreg_nxt   = bus.spi_data;
                    bit_cnt_nxt = '0;
                    if (bus.spi_cmd == 2'b01) begin
                        rst_n_nxt = 1'b0;
                    end else if (bus.spi_cmd[0] == 1'b0) begin
                        cs_n_nxt = 1'b0;
                        dc_nxt   = bus.spi_cmd[1];
                        mosi_nxt = bus.spi_data[7];
                    end
                end
            end
            SETUP, SHIFT_LO: if (phase_done) sclk_nxt = 1'b1;
            SHIFT_HI: begin
                if (phase_done) begin
                    sclk_nxt = 1'b0;
                    if (bit_cnt != 3'd7) begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        shreg_nxt   = {shreg[6:0], 1'b0};
                        mosi_nxt    = shreg[6];
                    end
                end
            end
            HOLD: begin
                if (cnt == CS_REL) cs_n_nxt = 1'b1;
                if (phase_done) begin
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                end
            end
            RSTPULSE: begin
                if (phase_done) begin
                    rst_n_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (phase_done) begin
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                end
            end
            ACK:     if (!bus.spi_start) ready_nxt = 1'b0;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lcd_spi_tx.sv
// Scoreboard bench for lcd_spi_tx: directed panel operations followed by a random mix,
// each issued operation queues its expected pin-level signature for the monitor.
module tb_lcd_spi_tx;
    localparam int CLK_DIV      = 2;
    localparam int RST_CYCLES   = 20;
    localparam int DELAY_CYCLES = 50;

    logic clk = 1'b0;
    logic reset;
    logic lcd_sclk, lcd_mosi, lcd_cs_n, lcd_dc, lcd_rst_n;

    lcd_spi_tx_if bus ();

    lcd_spi_tx #(.CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES), .DELAY_CYCLES(DELAY_CYCLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .lcd_sclk  (lcd_sclk),
        .lcd_mosi  (lcd_mosi),
        .lcd_cs_n  (lcd_cs_n),
        .lcd_dc    (lcd_dc),
        .lcd_rst_n (lcd_rst_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_byte;
        logic [7:0] bits;
        bit         dc;
        int         rises;
        int         cs_low;
        int         rst_low;
        int         latency;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Expected signature straight from the operation definitions.
    function automatic exp_t model(input logic [1:0] cmd, input logic [7:0] data);
        exp_t e;
        e = '{is_byte: 1'b0, bits: 8'h00, dc: 1'b0, rises: 0, cs_low: 0, rst_low: 0, latency: 0};
        case (cmd)
            2'b01: begin e.rst_low = RST_CYCLES; e.latency = RST_CYCLES; end
            2'b11: e.latency = DELAY_CYCLES;
            default: begin
                e.is_byte = 1'b1;
                e.bits    = data;
                e.dc      = cmd[1];
                e.rises   = 8;
                e.cs_low  = 17 * CLK_DIV;
                e.latency = 18 * CLK_DIV;
            end
        endcase
        return e;
    endfunction

    // Monitor: builds the observed signature of each operation and scores it when spi_ready rises.
    initial begin
        bit         active = 0, have_dc = 0;
        int         lat = 0, cs_low = 0, rst_low = 0, rises = 0, dc_chg = 0, idle_tog = 0;
        logic [7:0] bits = 0;
        logic       dc_first = 0;
        logic       p_busy = 0, p_ready = 0, p_sclk = 0, p_mosi = 0, p_dc = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 0;
            end else begin
                if (!active && bus.busy && !p_busy) begin
                    active = 1; have_dc = 0; lat = 0; cs_low = 0; rst_low = 0;
                    rises = 0; dc_chg = 0; idle_tog = 0; bits = 0;
                end else if (active) begin
                    lat++;
                end
                if (active) begin
                    if (!lcd_cs_n) begin
                        cs_low++;
                        if (!have_dc) begin dc_first = lcd_dc; have_dc = 1; end
                        else if (lcd_dc != dc_first) dc_chg++;
                    end else if (lcd_mosi != p_mosi || lcd_dc != p_dc) begin
                        idle_tog++;
                    end
                    if (!lcd_rst_n) rst_low++;
                    if (lcd_sclk && !p_sclk) begin
                        rises++;
                        bits = {bits[6:0], lcd_mosi};
                    end
                end
                if (bus.spi_ready && !p_ready) begin
                    if (!active || exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_ready: got spi_ready=1 with %0d pending, expected no ready (t=%0t)", exp_q.size(), $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("latency", lat, e.latency);
                        check("cs_low_cycles", cs_low, e.cs_low);
                        check("rst_low_cycles", rst_low, e.rst_low);
                        check("sclk_rises", rises, e.rises);
                        check("idle_pin_toggles", idle_tog, 0);
                        check("busy_at_ready", int'(bus.busy), 0);
                        if (e.is_byte) begin
                            check("mosi_bits", int'(bits), int'(e.bits));
                            check("dc_value", int'(dc_first), int'(e.dc));
                            check("dc_changes", dc_chg, 0);
                        end
                    end
                    active = 0;
                end
            end
            p_busy = bus.busy; p_ready = bus.spi_ready; p_sclk = lcd_sclk;
            p_mosi = lcd_mosi; p_dc = lcd_dc;
        end
    end

    task automatic issue(input logic [1:0] cmd, input logic [7:0] data);
        exp_q.push_back(model(cmd, data));
        @(negedge clk);
        bus.spi_start = 1'b1;
        bus.spi_cmd   = cmd;
        bus.spi_data  = data;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.spi_ready) begin ok = 1; return; end
        end
        n_cmp++; n_err++;
        $display("FAIL ready_timeout: got no spi_ready in 3000 cycles, expected one (t=%0t)", $time);
    endtask

    task automatic run_op(input logic [1:0] cmd, input logic [7:0] data, input int hold,
                          input bit scramble, input bit drop_early);
        bit ok;
        issue(cmd, data);
        if (scramble) begin
            repeat (3) @(negedge clk);
            bus.spi_data = 8'($urandom);
            bus.spi_cmd  = 2'($urandom);
        end
        if (drop_early) begin
            @(negedge clk);
            bus.spi_start = 1'b0;
        end
        wait_ready(ok);
        if (!ok) return;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("ready_held", int'(bus.spi_ready), 1);
            check("no_restart", int'(bus.busy), 0);
        end
        bus.spi_start = 1'b0;
        @(negedge clk);
        check("ready_fall", int'(bus.spi_ready), 0);
    endtask

    initial begin
        int   seen;
        logic ps;
        bus.spi_start = 1'b0;
        bus.spi_data  = 8'h00;
        bus.spi_cmd   = 2'b00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sclk", int'(lcd_sclk), 0);
        check("rst_mosi", int'(lcd_mosi), 0);
        check("rst_cs_n", int'(lcd_cs_n), 1);
        check("rst_dc", int'(lcd_dc), 0);
        check("rst_rst_n", int'(lcd_rst_n), 1);
        check("rst_ready", int'(bus.spi_ready), 0);
        check("rst_busy", int'(bus.busy), 0);
        reset = 1'b0;

        run_op(2'b10, 8'hA5, 0, 0, 0);
        run_op(2'b00, 8'h2C, 0, 0, 0);
        run_op(2'b10, 8'h5A, 10, 0, 0);
        run_op(2'b10, 8'hFF, 0, 1, 0);
        run_op(2'b01, 8'h00, 0, 0, 0);
        run_op(2'b11, 8'h00, 0, 0, 0);
        run_op(2'b00, 8'h81, 0, 0, 1);

        // Abort a byte during its 4th SCLK high phase.
        issue(2'b10, 8'($urandom));
        seen = 0;
        ps = 0;
        for (int i = 0; i < 200 && seen < 4; i++) begin
            @(negedge clk);
            if (lcd_sclk && !ps) seen++;
            ps = lcd_sclk;
        end
        check("fourth_rise_seen", seen, 4);
        reset = 1'b1;
        @(negedge clk);
        check("abort_cs_n", int'(lcd_cs_n), 1);
        check("abort_sclk", int'(lcd_sclk), 0);
        check("abort_ready", int'(bus.spi_ready), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_rst_n", int'(lcd_rst_n), 1);
        reset = 1'b0;
        bus.spi_start = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        run_op(2'b10, 8'h3C, 0, 0, 0);

        for (int n = 0; n < 16; n++) begin
            logic [1:0] c;
            c = 2'($urandom);
            run_op(c, 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end
        for (int n = 0; n < 4; n++)
            run_op(2'($urandom_range(0, 1)) << 1, 8'($urandom), 0, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
